// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending latch.
// Sizes the request vector and turns an acknowledge index into a bit mask.
package irq_pkg;

  localparam int N_IRQ = 4;
  localparam int ID_W  = 2;

  typedef logic [N_IRQ-1:0] irq_vec_t;

  // One-hot mask selecting the source named by an acknowledge index.
  function automatic irq_vec_t id_to_vec(input logic [ID_W-1:0] id);
    return irq_vec_t'(1) << id;
  endfunction

endpackage

// File: rtl/irq_pending_latch_sync_ff.sv
// Single-bit multi-stage synchronizer for one asynchronous request line.
// Every stage clears on reset so no stale request survives it.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: clocked state is written with <= so every stage samples the old value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/irq_pending_latch.sv
// Synchronizes four request lines, latches them as pending until acknowledged,
// and flags edges that arrive while the same source is still pending.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] mask,
  input  logic            ack,
  input  logic [ID_W-1:0] ack_id,
  input  logic            clear_ovf,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] overflow
);

  irq_vec_t irq_sync;
  irq_vec_t prev_q;
  irq_vec_t pending_q, pending_d;
  irq_vec_t overflow_q, overflow_d;
  irq_vec_t ack_vec;
  irq_vec_t capture;
  irq_vec_t ovf_set;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    sync_ff #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (irq_in[i]),
      .q_o  (irq_sync[i])
    );
  end

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    ack_vec    = '0;
    capture    = '0;
    ovf_set    = '0;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (ack) begin
      ack_vec = id_to_vec(ack_id);
    end

    if (EDGE_MODE) begin
      // A fresh edge beats a same-cycle ack; only an unacked edge on a pending bit is lost.
      capture = irq_sync & ~prev_q & mask;
      ovf_set = capture & pending_q & ~ack_vec;
    end else begin
      // A held level is not a new event, so the ack drops the bit for one cycle.
      capture = irq_sync & mask & ~ack_vec;
    end

    pending_d = (pending_q & ~ack_vec) | capture;

    if (clear_ovf) begin
      overflow_d = '0;
    end
    overflow_d = overflow_d | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      prev_q     <= irq_sync;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: one edge-mode and one level-mode
// instance share stimulus; expected values are hand-derived for SYNC_STAGES=2.
module tb_irq_pending_latch;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq_in;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] ack_id;
  logic       clear_ovf;
  logic [3:0] pend_e, ovf_e;
  logic [3:0] pend_l, ovf_l;

  int n_cmp = 0;
  int n_err = 0;

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .ack(ack),
    .ack_id(ack_id), .clear_ovf(clear_ovf), .pending(pend_e), .overflow(ovf_e)
  );

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .ack(ack),
    .ack_id(ack_id), .clear_ovf(clear_ovf), .pending(pend_l), .overflow(ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven 1ns later.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask = 4'hF; ack = 1'b0; ack_id = '0; clear_ovf = 1'b0;
    #3;
    chk("reset_pend_e", pend_e, 4'b0000);
    chk("reset_ovf_e",  ovf_e,  4'b0000);
    chk("reset_pend_l", pend_l, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("idle_pend_e", pend_e, 4'b0000);

    // Three-cycle pulse on source 2: pending after the third sampling edge.
    irq_in = 4'b0100;
    tick();  chk("s36_edge_n",   pend_e, 4'b0000);
    tick();  chk("s36_edge_n1",  pend_e, 4'b0000);
    tick();  chk("s36_edge_n2",  pend_e, 4'b0100);
    irq_in = 4'b0000;
    tick(3);
    chk("s36_hold_pend", pend_e, 4'b0100);
    chk("s36_hold_ovf",  ovf_e,  4'b0000);
    ack = 1'b1; ack_id = 2'd2;
    tick();
    ack = 1'b0;
    chk("s36_ack2", pend_e, 4'b0000);
    tick(4);

    // Ack of one bit leaves others; ack of an idle bit does nothing.
    irq_in = 4'b1010;
    tick(3);
    irq_in = 4'b0000;
    chk("s37_set", pend_e, 4'b1010);
    ack = 1'b1; ack_id = 2'd3;
    tick();  chk("s37_ack3", pend_e, 4'b0010);
    ack_id = 2'd0;
    tick();  chk("s37_ack0", pend_e, 4'b0010);
    ack = 1'b0;
    tick(4);

    // Second edge on a pending source sets sticky overflow.
    irq_in = 4'b0010;
    tick(3);
    chk("s38_ovf_set",  ovf_e,  4'b0010);
    chk("s38_pend",     pend_e, 4'b0010);
    irq_in = 4'b0000;
    tick();  chk("s38_ovf_sticky", ovf_e, 4'b0010);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("s38_ovf_clr", ovf_e, 4'b0000);
    ack = 1'b1; ack_id = 2'd1;
    tick();
    ack = 1'b0;
    chk("s38_ack1", pend_e, 4'b0000);
    tick(4);

    // Edge and ack on bit 0 in the same cycle: capture wins, no overflow.
    irq_in = 4'b0001;
    tick(3);
    irq_in = 4'b0000;
    chk("s39_pre", pend_e, 4'b0001);
    tick(4);
    irq_in = 4'b0001;
    tick(2);
    ack = 1'b1; ack_id = 2'd0;
    tick();
    ack = 1'b0;
    chk("s39_pend", pend_e, 4'b0001);
    chk("s39_ovf",  ovf_e,  4'b0000);
    irq_in = 4'b0000;
    ack = 1'b1; ack_id = 2'd0;
    tick();
    ack = 1'b0;
    chk("s39_clr", pend_e, 4'b0000);
    tick(4);

    // Masked source is discarded; unmasked one captures; unmasking keeps pending.
    mask = 4'b1110;
    irq_in = 4'b0001;
    tick(4);
    chk("s40_masked_pend", pend_e, 4'b0000);
    chk("s40_masked_ovf",  ovf_e,  4'b0000);
    irq_in = 4'b1000;
    tick(3);
    chk("s40_src3", pend_e, 4'b1000);
    mask = 4'b0000;
    tick();
    chk("s40_mask_off_keeps", pend_e, 4'b1000);
    mask = 4'hF;
    irq_in = 4'b0000;
    ack = 1'b1; ack_id = 2'd3;
    tick();
    ack = 1'b0;
    chk("s40_clr", pend_e, 4'b0000);
    tick(4);

    // Two sources in the same cycle.
    irq_in = 4'b0110;
    tick(3);
    chk("multi_src", pend_e, 4'b0110);
    irq_in = 4'b0000;
    tick(2);

    // Level mode: reset, then hold source 1 high from release.
    rst_n = 1'b0;
    #1;
    chk("lvl_rst_pend_e", pend_e, 4'b0000);
    tick();
    rst_n = 1'b1;
    irq_in = 4'b0010;
    tick(2);
    chk("lvl_pre_pend_l", pend_l, 4'b0000);
    tick();
    chk("lvl_set_pend_l", pend_l, 4'b0010);
    chk("lvl_set_pend_e", pend_e, 4'b0010);
    ack = 1'b1; ack_id = 2'd1;
    tick();
    ack = 1'b0;
    chk("lvl_ack_drop", pend_l, 4'b0000);
    chk("edge_ack_drop", pend_e, 4'b0000);
    tick();
    chk("lvl_reassert", pend_l, 4'b0010);
    chk("edge_no_recapture", pend_e, 4'b0000);
    chk("lvl_ovf", ovf_l, 4'b0000);

    // Mid-stream reset clears immediately; held line recaptured once after release.
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pend_l", pend_l, 4'b0000);
    chk("rst_mid_ovf_l",  ovf_l,  4'b0000);
    chk("rst_mid_pend_e", pend_e, 4'b0000);
    chk("rst_mid_ovf_e",  ovf_e,  4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rel_edge2_pend_e", pend_e, 4'b0000);
    tick();
    chk("rel_edge3_pend_e", pend_e, 4'b0010);
    chk("rel_edge3_pend_l", pend_l, 4'b0010);
    tick(3);
    chk("rel_once_pend_e", pend_e, 4'b0010);
    chk("rel_once_ovf_e",  ovf_e,  4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
